// File: rtl/noc_sink_pkg.sv
// Shared types for the NoC credit sink: packet-tracking state and the
// default-width flit entry layout stored in the receive FIFO.
package noc_sink_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_t;

  localparam int DEF_FLIT_WIDTH = 32;
  localparam int DEF_DEST_WIDTH = 4;

  // Default-width entry; modules with non-default widths declare their own
  // struct with the same field order so the packed layout matches.
  typedef struct packed {
    logic [DEF_FLIT_WIDTH-1:0] data;
    logic [DEF_DEST_WIDTH-1:0] dest;
    logic                      tail;
  } flit_entry_t;

endpackage

// File: rtl/noc_credit_sink_if.sv
// Output stream of the credit sink: valid/ready handshake carrying one flit
// per beat, with tail (m_last) and head-of-packet (m_first) marking.
interface noc_credit_sink_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int DEST_WIDTH = 4
);
  logic                  m_valid;
  logic                  m_ready;
  logic [FLIT_WIDTH-1:0] m_data;
  logic [DEST_WIDTH-1:0] m_dest;
  logic                  m_last;
  logic                  m_first;

  modport master (output m_valid, m_data, m_dest, m_last, m_first, input m_ready);
  modport slave  (input m_valid, m_data, m_dest, m_last, m_first, output m_ready);
endinterface

// File: rtl/noc_sink_fifo.sv
// Receive FIFO for the credit sink. Depth equals the upstream credit count,
// so it only fills completely when the consumer stalls. Full is judged on
// the current occupancy, so a same-cycle pop never makes room for a push.
module noc_sink_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 8
) (
  input  logic                     clk_noc,
  input  logic                     rst_n,
  input  logic                     push_req,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop_req,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full    = (occupancy == (AW+1)'(DEPTH));
  assign empty   = (occupancy == '0);
  assign push    = push_req && !full;
  assign pop     = pop_req && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk_noc or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Flit storage write port.
  always_ff @(posedge clk_noc) begin
    // NOTE: the storage array is deliberately not reset; occupancy gates every
    // read, so stale contents are never observed and the array maps to plain RAM.
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/noc_credit_sink.sv
// NoC credit sink: terminates the send/credit loop of one router output port.
// Buffers flits, presents them on a valid/ready stream with head marking,
// returns one registered credit per consumed flit, counts delivered packets.
// Optional build macro NOC_CREDIT_SINK_DEST_CHECK_EN enables the sticky
// err_dest check (destination change inside a packet); otherwise err_dest is 0.
module noc_credit_sink
  import noc_sink_pkg::*;
#(
  parameter int FLIT_WIDTH        = 32,
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_BUFFER_DEPTH = 8,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                               clk_noc,
  input  logic                               rst_n,
  input  logic [FLIT_WIDTH-1:0]              data_in,
  input  logic [DEST_WIDTH-1:0]              dest_in,
  input  logic                               is_tail_in,
  input  logic                               send_in,
  output logic                               credit_out,
  noc_credit_sink_if.master                  m,
  output logic [$clog2(FLIT_BUFFER_DEPTH):0] occupancy,
  output logic [CNT_WIDTH-1:0]               pkt_count,
  output logic                               err_overflow,
  output logic                               err_dest
);

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  tail;
  } entry_t;

  entry_t     wr_entry;
  entry_t     rd_entry;
  logic       full;
  logic       empty;
  logic       pop;
  logic       pkt_done;
  pkt_state_t state_q;
  pkt_state_t state_d;

  assign wr_entry = '{data: data_in, dest: dest_in, tail: is_tail_in};

  noc_sink_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FLIT_BUFFER_DEPTH)
  ) u_fifo (
    .clk_noc   (clk_noc),
    .rst_n     (rst_n),
    .push_req  (send_in),
    .wr_data   (wr_entry),
    .pop_req   (pop),
    .rd_data   (rd_entry),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

  assign m.m_valid = !empty;
  assign m.m_data  = rd_entry.data;
  assign m.m_dest  = rd_entry.dest;
  assign m.m_last  = rd_entry.tail;
  assign m.m_first = (state_q == IDLE);
  assign pop       = !empty && m.m_ready;

  // Packet state register.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Packet next-state: tracks head/body position of the flit at the FIFO head.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch forms.
    state_d  = state_q;
    pkt_done = 1'b0;
    if (pop) begin
      pkt_done = rd_entry.tail;
      case (state_q)
        IDLE:    if (!rd_entry.tail) state_d = IN_PKT;
        IN_PKT:  if (rd_entry.tail)  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Credit return, delivered-packet counter and sticky overflow flag.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      credit_out   <= 1'b0;
      pkt_count    <= '0;
      err_overflow <= 1'b0;
    end else begin
      credit_out <= pop;
      if (pkt_done)        pkt_count    <= pkt_count + 1'b1;
      if (send_in && full) err_overflow <= 1'b1;
    end
  end

`ifdef NOC_CREDIT_SINK_DEST_CHECK_EN
  logic [DEST_WIDTH-1:0] head_dest_q;

  // Latch the head destination and flag any body flit that disagrees with it.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      head_dest_q <= '0;
      err_dest    <= 1'b0;
    end else if (pop) begin
      if (state_q == IDLE)                 head_dest_q <= rd_entry.dest;
      else if (rd_entry.dest != head_dest_q) err_dest  <= 1'b1;
    end
  end
`else
  assign err_dest = 1'b0;
`endif

endmodule

// File: tb/tb_noc_credit_sink.sv
// Bench for noc_credit_sink: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a queue model.
module tb_noc_credit_sink;

  localparam int FW    = 32;
  localparam int DW    = 4;
  localparam int DEPTH = 8;
  localparam int CW    = 16;

  logic          clk_noc = 1'b0;
  logic          rst_n   = 1'b0;
  logic [FW-1:0] data_in = '0;
  logic [DW-1:0] dest_in = '0;
  logic          is_tail_in = 1'b0;
  logic          send_in = 1'b0;
  logic          credit_out;
  logic [3:0]    occupancy;
  logic [CW-1:0] pkt_count;
  logic          err_overflow;
  logic          err_dest;

  noc_credit_sink_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW)) m_if ();

  noc_credit_sink #(
    .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk_noc      (clk_noc),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .dest_in      (dest_in),
    .is_tail_in   (is_tail_in),
    .send_in      (send_in),
    .credit_out   (credit_out),
    .m            (m_if.master),
    .occupancy    (occupancy),
    .pkt_count    (pkt_count),
    .err_overflow (err_overflow),
    .err_dest     (err_dest)
  );

  always #5 clk_noc = ~clk_noc;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [FW-1:0] d;
    logic [DW-1:0] de;
    logic          t;
  } flit_t;

  flit_t         q[$];
  bit            in_pkt;
  bit            exp_credit;
  bit            exp_ovf;
  bit            exp_derr;
  int            exp_pkts;
  logic [DW-1:0] head_dest;

  always @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      in_pkt     = 0;
      exp_credit = 0;
      exp_ovf    = 0;
      exp_derr   = 0;
      exp_pkts   = 0;
      head_dest  = '0;
    end else begin
      bit    do_pop;
      bit    was_full;
      flit_t f;
      was_full = (q.size() == DEPTH);
      do_pop   = (q.size() != 0) && m_if.m_ready;
      exp_credit = do_pop;
      if (send_in && was_full) exp_ovf = 1;
      if (do_pop) begin
        f = q.pop_front();
        if (!in_pkt) head_dest = f.de;
        else if (f.de != head_dest) begin
`ifdef NOC_CREDIT_SINK_DEST_CHECK_EN
          exp_derr = 1;
`endif
        end
        if (f.t) begin
          exp_pkts = (exp_pkts + 1) % (1 << CW);
          in_pkt   = 0;
        end else begin
          in_pkt = 1;
        end
      end
      if (send_in && !was_full) q.push_back('{d: data_in, de: dest_in, t: is_tail_in});
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk_noc) begin
    if (rst_n) begin
      check("occupancy", occupancy, q.size());
      check("m_valid", m_if.m_valid, q.size() != 0);
      if (q.size() != 0) begin
        check("m_data", m_if.m_data, q[0].d);
        check("m_dest", m_if.m_dest, q[0].de);
        check("m_last", m_if.m_last, q[0].t);
      end
      check("m_first", m_if.m_first, !in_pkt);
      check("credit_out", credit_out, exp_credit);
      check("pkt_count", pkt_count, exp_pkts);
      check("err_overflow", err_overflow, exp_ovf);
      check("err_dest", err_dest, exp_derr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit s, input logic [FW-1:0] d, input logic [DW-1:0] de,
                       input bit t, input bit r);
    send_in    = s;
    data_in    = d;
    dest_in    = de;
    is_tail_in = t;
    m_if.m_ready = r;
    @(posedge clk_noc);
    #1;
  endtask

  int base;

  initial begin
    m_if.m_ready = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk_noc);
    #1;

    // Reset state
    check("rst m_valid", m_if.m_valid, 0);
    check("rst occupancy", occupancy, 0);
    check("rst m_first", m_if.m_first, 1);
    check("rst credit", credit_out, 0);
    check("rst pkt_count", pkt_count, 0);
    check("rst err_overflow", err_overflow, 0);

    // 1: single-flit packet
    drive(1, 32'hA5A5A5A5, 4'h3, 1, 1);
    check("t1 m_valid", m_if.m_valid, 1);
    check("t1 m_first", m_if.m_first, 1);
    check("t1 m_last", m_if.m_last, 1);
    check("t1 m_data", m_if.m_data, 32'hA5A5A5A5);
    check("t1 credit before pop", credit_out, 0);
    drive(0, '0, '0, 0, 1);
    check("t1 credit", credit_out, 1);
    check("t1 pkt_count", pkt_count, 1);
    drive(0, '0, '0, 0, 1);
    check("t1 credit end", credit_out, 0);

    // 2: fill with consumer stalled, then one overflow push
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'h1000 + i, 4'h5, i == DEPTH - 1, 0);
      check("t2 no credit", credit_out, 0);
    end
    check("t2 occupancy", occupancy, 8);
    check("t2 no overflow", err_overflow, 0);
    drive(1, 32'hDEAD, 4'h5, 0, 0);
    check("t2 overflow", err_overflow, 1);
    check("t2 occupancy held", occupancy, 8);

    // 3: drain; credits back-to-back for exactly 8 cycles
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, '0, '0, 0, 1);
      check("t3 credit run", credit_out, 1);
    end
    drive(0, '0, '0, 0, 1);
    check("t3 credit stops", credit_out, 0);
    check("t3 occupancy", occupancy, 0);
    check("t3 pkt_count", pkt_count, 2);

    // 4: 4-flit packet streamed with push and pop every cycle
    base = pkt_count;
    drive(1, 32'h40, 4'h7, 0, 1);
    check("t4 first head", m_if.m_first, 1);
    for (int i = 1; i < 4; i++) begin
      drive(1, 32'h40 + i, 4'h7, i == 3, 1);
      check("t4 occupancy", occupancy, 1);
      check("t4 m_first body", m_if.m_first, 0);
    end
    check("t4 pkt before tail pop", pkt_count, base);
    drive(0, '0, '0, 0, 1);
    check("t4 pkt_count", pkt_count, base + 1);

    // 5: reset after two flits of a 4-flit packet are delivered
    for (int i = 0; i < 4; i++) drive(1, 32'h50 + i, 4'h9, i == 3, 0);
    drive(0, '0, '0, 0, 1);
    drive(0, '0, '0, 0, 1);
    check("t5 mid-packet", m_if.m_first, 0);
    m_if.m_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    check("t5 rst m_valid", m_if.m_valid, 0);
    check("t5 rst occupancy", occupancy, 0);
    check("t5 rst m_first", m_if.m_first, 1);
    check("t5 rst credit", credit_out, 0);
    check("t5 rst pkt_count", pkt_count, 0);
    check("t5 rst err_overflow", err_overflow, 0);
    rst_n = 1'b1;
    drive(1, 32'h77, 4'h9, 1, 0);
    check("t5 head after reset", m_if.m_first, 1);
    check("t5 head valid", m_if.m_valid, 1);
    drive(0, '0, '0, 0, 1);
    check("t5 pkt after reset", pkt_count, 1);

    // 6: destination change inside a packet
    drive(1, 32'h61, 4'h1, 0, 1);
    drive(1, 32'h62, 4'h2, 1, 1);
    drive(0, '0, '0, 0, 1);
`ifdef NOC_CREDIT_SINK_DEST_CHECK_EN
    check("t6 err_dest", err_dest, 1);
`else
    check("t6 err_dest", err_dest, 0);
`endif
    check("t6 delivered", pkt_count, 2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 6, $urandom, 4'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 5);
    end
    for (int i = 0; i < 12; i++) drive(0, '0, '0, 0, 1);
    check("final drained", occupancy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
